// File: rtl/son_split_if.sv
// son_split_if: handshake bundle for son_stream_splitter.
//   din / din_valid / din_ready          - 16-bit input result stream
//   dout_chN / dout_valid_chN / dout_ready_chN (N = 0..2) - 11-bit channel streams
// Words are two's-complement signed values carried as plain logic vectors.
//
// Handshake: a word moves across a link in every cycle where valid and ready
// are both high at the rising clock edge. A producer that raises valid keeps
// it high and keeps the data stable until that transfer happens; ready may
// change freely and never depends on being asked.
//
// Modports: master = stream source / channel consumer (e.g. the bench),
//           slave  = the splitter itself.
interface son_split_if;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [10:0] dout_ch0;
  logic [10:0] dout_ch1;
  logic [10:0] dout_ch2;
  logic        dout_valid_ch0;
  logic        dout_valid_ch1;
  logic        dout_valid_ch2;
  logic        dout_ready_ch0;
  logic        dout_ready_ch1;
  logic        dout_ready_ch2;

  modport master (
    output din, din_valid, dout_ready_ch0, dout_ready_ch1, dout_ready_ch2,
    input  din_ready, dout_ch0, dout_ch1, dout_ch2,
    input  dout_valid_ch0, dout_valid_ch1, dout_valid_ch2
  );

  modport slave (
    input  din, din_valid, dout_ready_ch0, dout_ready_ch1, dout_ready_ch2,
    output din_ready, dout_ch0, dout_ch1, dout_ch2,
    output dout_valid_ch0, dout_valid_ch1, dout_valid_ch2
  );
endinterface

// File: rtl/son_stream_splitter.sv
// son_stream_splitter: splits one 16-bit signed result stream into three
// 11-bit signed channel streams, each buffered by its own FIFO.
//
// Ports:
//   clk           - single clock
//   rst_n         - asynchronous active-low reset
//   cfg_of_split  - [1:0] route mode (0 round-robin, 1 broadcast, 2 tagged,
//                   3 discard), [3:2] arithmetic right-shift amount
//   bus (slave)   - din/din_valid/din_ready input stream and the three
//                   dout_chN/dout_valid_chN/dout_ready_chN channel streams
//   drop_cnt      - saturating count of accepted-but-discarded words
//   sat_flag      - (SPLIT_SAT_EN only) sticky: some written word saturated
//
// Build option: define SPLIT_SAT_EN to clamp the 16->11 narrowing to
// [-1024, +1023] and add sat_flag; otherwise the value is truncated.
module son_stream_splitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cfg_of_split,
  son_split_if.slave            bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef SPLIT_SAT_EN
  , output logic                sat_flag
`endif
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    MODE_RR      = 2'd0,
    MODE_BCAST   = 2'd1,
    MODE_TAGGED  = 2'd2,
    MODE_DISCARD = 2'd3
  } mode_e;

  mode_e       mode;
  mode_e       prev_mode;
  logic [1:0]  shift;
  logic [1:0]  rr_ptr;
  logic [1:0]  rr_eff;
  logic [1:0]  tag;

  logic [10:0]   mem    [3][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [AW:0]   count  [3];

  logic [3:0]  full_x;   // bit 3 is a constant 0 so a 2-bit index is always in range
  logic [2:0]  wr_en;
  logic [2:0]  rd_en;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic        ready_c;
  logic        accept;
  logic        drop;

  logic signed [15:0] payload;
  logic signed [15:0] value;
  logic [10:0]        conv;
`ifdef SPLIT_SAT_EN
  logic               conv_sat;
`endif

  assign mode  = mode_e'(cfg_of_split[1:0]);
  assign shift = cfg_of_split[3:2];
  assign tag   = bus.din[15:14];

  // A mode change seen this cycle restarts round-robin at channel 0 for the
  // word accepted in this very cycle, not one cycle later.
  assign rr_eff = (mode != prev_mode) ? 2'd0 : rr_ptr;

  assign ready = {bus.dout_ready_ch2, bus.dout_ready_ch1, bus.dout_ready_ch0};

  always_comb begin
    full_x = 4'b0000;
    valid  = 3'b000;
    for (int c = 0; c < 3; c++) begin
      full_x[c] = (count[c] == FULL_CNT);
      valid[c]  = (count[c] != '0);
    end
  end

  assign rd_en = valid & ready;

  // Readiness depends only on "full", never on a same-cycle read, so a full
  // FIFO cannot be written even if its consumer is popping.
  always_comb begin
    ready_c = 1'b0;
    case (mode)
      MODE_RR:      ready_c = !full_x[rr_eff];
      MODE_BCAST:   ready_c = (full_x[2:0] == 3'b000);
      MODE_TAGGED:  ready_c = (tag == 2'd3) ? 1'b1 : !full_x[tag];
      MODE_DISCARD: ready_c = 1'b1;
      default:      ready_c = 1'b0;
    endcase
  end

  assign bus.din_ready = rst_n & ready_c;
  assign accept        = bus.din_valid & bus.din_ready;

  always_comb begin
    wr_en = 3'b000;
    for (int c = 0; c < 3; c++) begin
      case (mode)
        MODE_RR:     wr_en[c] = accept && (rr_eff == 2'(c));
        MODE_BCAST:  wr_en[c] = accept;
        MODE_TAGGED: wr_en[c] = accept && (tag == 2'(c));
        default:     wr_en[c] = 1'b0;
      endcase
    end
  end

  assign drop = accept && ((mode == MODE_DISCARD) ||
                           ((mode == MODE_TAGGED) && (tag == 2'd3)));

  // Tagged words carry a 14-bit signed payload below the tag.
  assign payload = (mode == MODE_TAGGED) ? {{2{bus.din[13]}}, bus.din[13:0]}
                                         : bus.din;
  assign value   = payload >>> shift;

  always_comb begin
`ifdef SPLIT_SAT_EN
    conv_sat = 1'b0;
    conv     = value[10:0];
    if (value > 16'sd1023) begin
      conv     = 11'h3FF;
      conv_sat = 1'b1;
    end else if (value < -16'sd1024) begin
      conv     = 11'h400;
      conv_sat = 1'b1;
    end
`else
    conv = value[10:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_mode <= MODE_RR;
      rr_ptr    <= 2'd0;
      drop_cnt  <= '0;
`ifdef SPLIT_SAT_EN
      sat_flag  <= 1'b0;
`endif
      for (int c = 0; c < 3; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem[c][i] <= '0;
        end
      end
    end else begin
      prev_mode <= mode;
      if ((mode == MODE_RR) && accept) begin
        rr_ptr <= (rr_eff == 2'd2) ? 2'd0 : rr_eff + 2'd1;
      end else begin
        rr_ptr <= rr_eff;
      end

      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

`ifdef SPLIT_SAT_EN
      if ((wr_en != 3'b000) && conv_sat) begin
        sat_flag <= 1'b1;
      end
`endif

      for (int c = 0; c < 3; c++) begin
        if (wr_en[c]) begin
          mem[c][wr_ptr[c]] <= conv;
          wr_ptr[c]         <= wr_ptr[c] + PTR_ONE;
        end
        if (rd_en[c]) begin
          rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        end
        case ({wr_en[c], rd_en[c]})
          2'b10:   count[c] <= count[c] + CNT_ONE;
          2'b01:   count[c] <= count[c] - CNT_ONE;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // Channel outputs come straight from each FIFO's head entry.
  assign bus.dout_ch0       = mem[0][rd_ptr[0]];
  assign bus.dout_ch1       = mem[1][rd_ptr[1]];
  assign bus.dout_ch2       = mem[2][rd_ptr[2]];
  assign bus.dout_valid_ch0 = valid[0];
  assign bus.dout_valid_ch1 = valid[1];
  assign bus.dout_valid_ch2 = valid[2];

endmodule

// File: tb/tb_son_stream_splitter.sv
// tb_son_stream_splitter: directed + randomized bench for son_stream_splitter.
// A queue-based channel model predicts din_ready, every channel's valid/data,
// drop_cnt (and sat_flag when SPLIT_SAT_EN is defined) cycle by cycle.
module tb_son_stream_splitter;

  localparam int DEPTH  = 4;
  localparam int DW     = 8;
  localparam int DROP_MAX = (1 << DW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    cfg;
  logic [DW-1:0] drop_cnt;
`ifdef SPLIT_SAT_EN
  logic          sat_flag;
`endif

  son_split_if bus ();

  son_stream_splitter #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_of_split (cfg),
    .bus          (bus),
    .drop_cnt     (drop_cnt)
`ifdef SPLIT_SAT_EN
    , .sat_flag   (sat_flag)
`endif
  );

  // scoreboard / reference model state
  logic [10:0] exp_q [3][$];
  int  model_rr;
  int  model_last_mode;
  int  model_drop;
  bit  model_sat;
  int  n_cmp;
  int  n_err;
  int  n_acc;
  int  n_pop [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input int c);
    case (c)
      0:       return bus.dout_valid_ch0;
      1:       return bus.dout_valid_ch1;
      default: return bus.dout_valid_ch2;
    endcase
  endfunction

  function automatic logic [10:0] get_data(input int c);
    case (c)
      0:       return bus.dout_ch0;
      1:       return bus.dout_ch1;
      default: return bus.dout_ch2;
    endcase
  endfunction

  task automatic set_ready(input logic [2:0] r);
    bus.dout_ready_ch0 = r[0];
    bus.dout_ready_ch1 = r[1];
    bus.dout_ready_ch2 = r[2];
  endtask

  function automatic logic get_ready(input int c);
    case (c)
      0:       return bus.dout_ready_ch0;
      1:       return bus.dout_ready_ch1;
      default: return bus.dout_ready_ch2;
    endcase
  endfunction

  // Reference conversion done with integer arithmetic.
  function automatic logic [10:0] convert(input int mode, input int sh,
                                          input logic [15:0] w, output bit sat);
    int p;
    int v;
    logic [31:0] vv;
    if (mode == 2) p = w[13] ? int'(w[13:0]) - 16384 : int'(w[13:0]);
    else           p = w[15] ? int'(w) - 65536 : int'(w);
    v   = p >>> sh;
    sat = 1'b0;
`ifdef SPLIT_SAT_EN
    if (v > 1023)       begin v = 1023;  sat = 1'b1; end
    else if (v < -1024) begin v = -1024; sat = 1'b1; end
`endif
    vv = v;
    return vv[10:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) exp_q[c].delete();
    model_rr        = 0;
    model_last_mode = 0;
    model_drop      = 0;
    model_sat       = 1'b0;
  endtask

  // One clock: check at the falling edge, let the rising edge happen, then
  // advance the model with the decisions taken at the falling edge.
  task automatic cycle();
    int  mode;
    int  sh;
    int  eff_rr;
    int  tag;
    bit  exp_ready;
    bit  acc;
    bit  pop [3];
    bit  sat;
    logic [15:0] w;
    logic [10:0] cv;
    @(negedge clk);
    mode   = int'(cfg[1:0]);
    sh     = int'(cfg[3:2]);
    w      = bus.din;
    tag    = int'(w[15:14]);
    eff_rr = (mode != model_last_mode) ? 0 : model_rr;
    case (mode)
      0:       exp_ready = exp_q[eff_rr].size() < DEPTH;
      1:       exp_ready = (exp_q[0].size() < DEPTH) && (exp_q[1].size() < DEPTH) &&
                           (exp_q[2].size() < DEPTH);
      2:       exp_ready = (tag == 3) ? 1'b1 : (exp_q[tag].size() < DEPTH);
      default: exp_ready = 1'b1;
    endcase
    check("din_ready", bus.din_ready, exp_ready);
    check("drop_cnt", drop_cnt, model_drop);
`ifdef SPLIT_SAT_EN
    check("sat_flag", sat_flag, model_sat);
`endif
    for (int c = 0; c < 3; c++) begin
      check($sformatf("valid_ch%0d", c), get_valid(c), exp_q[c].size() != 0);
      if (exp_q[c].size() != 0) check($sformatf("data_ch%0d", c), get_data(c), exp_q[c][0]);
      pop[c] = (exp_q[c].size() != 0) && get_ready(c);
    end
    acc = bus.din_valid && exp_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      if (pop[c]) begin
        void'(exp_q[c].pop_front());
        n_pop[c]++;
      end
    end
    model_rr = eff_rr;
    if (acc) begin
      n_acc++;
      cv = convert(mode, sh, w, sat);
      case (mode)
        0: begin
          exp_q[eff_rr].push_back(cv);
          model_rr = (eff_rr + 1) % 3;
          if (sat) model_sat = 1'b1;
        end
        1: begin
          for (int c = 0; c < 3; c++) exp_q[c].push_back(cv);
          if (sat) model_sat = 1'b1;
        end
        2: begin
          if (tag == 3) begin
            if (model_drop < DROP_MAX) model_drop++;
          end else begin
            exp_q[tag].push_back(cv);
            if (sat) model_sat = 1'b1;
          end
        end
        default: if (model_drop < DROP_MAX) model_drop++;
      endcase
    end
    model_last_mode = mode;
  endtask

  task automatic send(input logic [3:0] c, input logic [15:0] d);
    cfg           = c;
    bus.din       = d;
    bus.din_valid = 1'b1;
    cycle();
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int   acc_before;
    logic [10:0] held;
    n_cmp = 0;
    n_err = 0;
    n_acc = 0;
    for (int c = 0; c < 3; c++) n_pop[c] = 0;
    cfg           = 4'h0;
    bus.din       = 16'h0;
    bus.din_valid = 1'b0;
    set_ready(3'b111);
    model_reset();

    // reset values while rst_n is low
    #12;
    check("rst_din_ready", bus.din_ready, 1'b0);
    check("rst_drop_cnt", drop_cnt, 0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst_valid_ch%0d", c), get_valid(c), 1'b0);
      check($sformatf("rst_data_ch%0d", c), get_data(c), 11'h000);
    end
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // round-robin 1,2,3,4 back to back
    cfg = 4'h0;
    bus.din_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.din = 16'(i);
      cycle();
    end
    idle(3);

    // broadcast with ch1 stalled for 6 cycles
    for (int c = 0; c < 3; c++) n_pop[c] = 0;
    set_ready(3'b101);
    cfg = 4'h1;
    bus.din = 16'h0123;
    bus.din_valid = 1'b1;
    acc_before = n_acc;
    held = 11'h000;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 0) held = bus.dout_ch1;
      else check("ch1_stable", bus.dout_ch1, held);
    end
    check("bcast_accepts", n_acc - acc_before, 4);
    check("bcast_held_value", held, 11'h123);
    set_ready(3'b111);
    idle(6);
    check("bcast_ch0_words", n_pop[0], 4);
    check("bcast_ch1_words", n_pop[1], 4);
    check("bcast_ch2_words", n_pop[2], 4);

    // tagged mode
    send(4'h2, 16'h4005);
    send(4'h2, 16'h3FFF);
    cfg = 4'h2;
    bus.din = 16'hC00A;
    bus.din_valid = 1'b1;
    #1 check("tag3_ready", bus.din_ready, 1'b1);
    cycle();
    bus.din_valid = 1'b0;
    idle(2);
    check("tag3_drop_cnt", drop_cnt, 1);

    // shift and narrowing
    send(4'h8, 16'hFFF0);
    send(4'h0, 16'h1000);
    idle(2);

    // discard mode: counter saturates, then round-robin restarts at ch0
    cfg = 4'h3;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.din = 16'($urandom);
      cycle();
    end
    check("drop_saturated", drop_cnt, DROP_MAX);
    for (int c = 0; c < 3; c++) n_pop[c] = 0;
    send(4'h0, 16'h0007);
    idle(2);
    check("rr_restart_ch0", n_pop[0], 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) cfg = 4'($urandom_range(0, 15));
      bus.din       = 16'($urandom);
      bus.din_valid = ($urandom_range(0, 3) != 0);
      set_ready(3'($urandom_range(0, 7)));
      cycle();
    end
    set_ready(3'b111);
    idle(6);

    // reset while every FIFO holds two words
    set_ready(3'b000);
    send(4'h1, 16'h0011);
    send(4'h1, 16'h0022);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++)
      check($sformatf("midrst_valid_ch%0d", c), get_valid(c), 1'b0);
    check("midrst_din_ready", bus.din_ready, 1'b0);
    model_reset();
    set_ready(3'b111);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) n_pop[c] = 0;
    send(4'h0, 16'h0055);
    idle(2);
    check("post_rst_ch0", n_pop[0], 1);
    check("post_rst_ch1", n_pop[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
